lsu: RTL and testbench

Load/store unit for the MEM stage of the RISC-V pipeline. It takes the effective address produced by EX (`ALU_result`) together with the store operand and the `MemRead`/`MemWrite` controls. It runs a single outstanding valid/ack transaction against data memory and returns lane-aligned, sign- or zero-extended load data to write-back. It stalls the front of the pipeline while a transaction is in flight.

---
 rtl/lsu_if.sv | 26 ++
 rtl/lsu.sv | 196 +++++++++++++++++++
 tb/tb_lsu.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and data memory.
// One outstanding request: dmem_req is held with constant addr/be/we/wdata
// until memory answers with a one-cycle dmem_ack (dmem_rdata valid then).
//   master : LSU side   (drives req/we/addr/be/wdata, samples rdata/ack)
//   slave  : memory side
interface lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit for the MEM stage.
// Accepts one load or store from EX, runs a single valid/ack transaction on
// the data-memory bus and returns lane-aligned, extended load data.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   EX handshake (ready only in IDLE)
//   MemRead, MemWrite     direction controls
//   funct3                size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALU_result            effective byte address
//   store_data, rd_in     store operand, load destination register
//   dmem                  data-memory bus (lsu_if master)
//   load_valid/data/rd    one-cycle registered load result
//   fault                 one-cycle pulse when an operation is dropped
//   stall                 high while a transaction is in flight
module lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ALU_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  lsu_if.master           dmem,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic [4:0]      load_rd,
  output logic            fault,
  output logic            stall
);

  localparam int unsigned CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  // Last count value at which a missing ack still keeps the request alive.
  localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT == 0) ? '0 : CW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_valid_q, load_valid_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [4:0]      load_rd_q, load_rd_d;
  logic            fault_q, fault_d;

  logic            accept;
  logic            bad_op;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] load_ext;

  assign accept = req_valid & (state_q == IDLE) & (MemRead | MemWrite);

  // Request decode from the live EX inputs: legality, lanes, store data.
  always_comb begin
    bad_op = 1'b0;
    if (MemRead && MemWrite) begin
      bad_op = 1'b1;
    end else if (MemRead) begin
      if (funct3[1:0] == 2'b11 || (funct3[2] && funct3[1])) bad_op = 1'b1;
    end else begin
      if (funct3[2] || funct3[1:0] == 2'b11) bad_op = 1'b1;
    end
    if (funct3[1:0] == 2'b01 && ALU_result[0])          bad_op = 1'b1;
    if (funct3[1:0] == 2'b10 && ALU_result[1:0] != 2'b00) bad_op = 1'b1;

    be_new    = 4'b1111;
    wdata_new = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALU_result[1:0];
        wdata_new = {(XLEN/8){store_data[7:0]}};
      end
      2'b01: begin
        be_new    = ALU_result[1] ? 4'b1100 : 4'b0011;
        wdata_new = {(XLEN/16){store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the latched address/size.
  always_comb begin
    rdata_sh = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q[1:0])
      2'b00:   load_ext = {{(XLEN-8){~f3_q[2] & rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   load_ext = {{(XLEN-16){~f3_q[2] & rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = ALU_result;
          f3_d    = funct3;
          we_d    = MemWrite;
          be_d    = be_new;
          wdata_d = wdata_new;
          rd_d    = rd_in;
          if (bad_op) begin
            fault_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = load_ext;
            load_rd_d    = rd_q;
          end
        end else if (ACK_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          // This cycle's missing ack brings the count to ACK_TIMEOUT.
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
      fault_q      <= fault_d;
    end
  end

  // Request decodes straight from state so reset drops it asynchronously.
  assign req_ready       = (state_q == IDLE);
  assign stall           = (state_q != IDLE);
  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign load_valid      = load_valid_q;
  assign load_data       = load_data_q;
  assign load_rd         = load_rd_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized loads/stores checked against
// an arithmetic model of the address/lane/extension rules.
module tb_lsu;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALU_result, store_data;
  logic [4:0]  rd_in;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        fault, stall;

  int n_checks = 0;
  int n_errors = 0;

  lsu_if #(.XLEN(32)) dmem_bus ();

  lsu #(.XLEN(32), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALU_result(ALU_result), .store_data(store_data), .rd_in(rd_in),
    .dmem(dmem_bus),
    .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
    .fault(fault), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_req", dmem_bus.dmem_req, 0);
    check_eq("rst_we", dmem_bus.dmem_we, 0);
    check_eq("rst_be", dmem_bus.dmem_be, 0);
    check_eq("rst_addr", dmem_bus.dmem_addr, 0);
    check_eq("rst_wdata", dmem_bus.dmem_wdata, 0);
    check_eq("rst_lvalid", load_valid, 0);
    check_eq("rst_ldata", load_data, 0);
    check_eq("rst_lrd", load_rd, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_stall", stall, 0);
  endtask

  // Reference rules
  function automatic bit model_bad(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz = int'(f3) % 4;
    if (rd && wr) return 1;
    if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    if (wr && f3 > 2) return 1;
    if (sz == 1 && (a % 2) != 0) return 1;
    if (sz == 2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    case (int'(f3) % 4)
      0:       return 4'(1 << off);
      1:       return (off >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (int'(f3) % 4)
      0:       return (d % 256) * 32'h0101_0101;
      1:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int off = int'(a % 4);
    case (int'(f3))
      0: begin v = (w >> (8 * off)) % 256;   return (v >= 128)   ? v - 256   : v; end
      4: begin v = (w >> (8 * off)) % 256;   return v; end
      1: begin v = (w >> (8 * off)) % 65536; return (v >= 32768) ? v - 65536 : v; end
      5: begin v = (w >> (8 * off)) % 65536; return v; end
      default: return w;
    endcase
  endfunction

  // One complete operation from an IDLE cycle. delay = BUSY cycles before the
  // ack arrives; delay >= TMO means memory never answers.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] tag,
                       input int delay, input logic [31:0] rdata);
    bit acked = 0;
    bit bad   = model_bad(rd, wr, f3, a);
    check_eq("pre_ready", req_ready, 1);
    req_valid = 1; MemRead = rd; MemWrite = wr; funct3 = f3;
    ALU_result = a; store_data = sd; rd_in = tag;
    step();
    req_valid = 0; MemRead = 0; MemWrite = 0; ALU_result = $urandom; store_data = $urandom;
    if (!rd && !wr) begin
      check_eq("ign_req", dmem_bus.dmem_req, 0);
      check_eq("ign_fault", fault, 0);
      check_eq("ign_ready", req_ready, 1);
      return;
    end
    if (bad) begin
      check_eq("bad_fault", fault, 1);
      check_eq("bad_req", dmem_bus.dmem_req, 0);
      check_eq("bad_ready", req_ready, 1);
      check_eq("bad_lvalid", load_valid, 0);
      step();
      check_eq("bad_fault_pulse", fault, 0);
      check_eq("bad_req2", dmem_bus.dmem_req, 0);
      return;
    end
    for (int c = 0; c < TMO; c++) begin
      check_eq("busy_req", dmem_bus.dmem_req, 1);
      check_eq("busy_stall", stall, 1);
      check_eq("busy_ready", req_ready, 0);
      check_eq("busy_addr", dmem_bus.dmem_addr, a & 32'hFFFF_FFFC);
      check_eq("busy_be", dmem_bus.dmem_be, model_be(f3, a));
      check_eq("busy_we", dmem_bus.dmem_we, wr);
      if (wr) check_eq("busy_wdata", dmem_bus.dmem_wdata, model_wdata(f3, sd));
      if (c == delay) begin
        dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = rdata;
        step();
        dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = $urandom;
        acked = 1;
        break;
      end
      dmem_bus.dmem_rdata = $urandom;
      step();
    end
    check_eq("done_req", dmem_bus.dmem_req, 0);
    check_eq("done_ready", req_ready, 1);
    check_eq("done_stall", stall, 0);
    if (!acked) begin
      check_eq("tmo_fault", fault, 1);
      check_eq("tmo_lvalid", load_valid, 0);
    end else if (rd) begin
      check_eq("ld_valid", load_valid, 1);
      check_eq("ld_data", load_data, model_load(f3, a, rdata));
      check_eq("ld_rd", load_rd, tag);
      check_eq("ld_fault", fault, 0);
    end else begin
      check_eq("st_lvalid", load_valid, 0);
      check_eq("st_fault", fault, 0);
    end
    step();
    check_eq("post_lvalid", load_valid, 0);
    check_eq("post_fault", fault, 0);
  endtask

  initial begin
    rst = 1; req_valid = 0; MemRead = 0; MemWrite = 0; funct3 = 0;
    ALU_result = 0; store_data = 0; rd_in = 0;
    dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = 0;
    step(); step();
    check_reset_values();
    rst = 0;
    step();

    // LB 0x103, ack one cycle after req
    do_op(1, 0, 3'b000, 32'h103, 0, 5'd7, 1, 32'h80FF_1234);
    // LHU / LH at 0x102
    do_op(1, 0, 3'b101, 32'h102, 0, 5'd9, 0, 32'hBEEF_0000);
    do_op(1, 0, 3'b001, 32'h102, 0, 5'd10, 2, 32'hBEEF_0000);
    // SB 0x201
    do_op(0, 1, 3'b000, 32'h201, 32'h1234_56AB, 5'd0, 2, 32'h0);
    // misaligned LW and SH
    do_op(1, 0, 3'b010, 32'h302, 0, 5'd3, 0, 0);
    do_op(0, 1, 3'b001, 32'h305, 32'hFFFF_0000, 5'd0, 0, 0);
    // timeout: no ack
    do_op(1, 0, 3'b010, 32'h400, 0, 5'd12, 99, 0);
    // late ack after timeout is ignored
    dmem_bus.dmem_ack = 1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_bus.dmem_ack = 0;
    check_eq("late_req", dmem_bus.dmem_req, 0);
    check_eq("late_lvalid", load_valid, 0);
    check_eq("late_fault", fault, 0);
    check_eq("late_ready", req_ready, 1);

    // reset while an LW is in BUSY
    req_valid = 1; MemRead = 1; funct3 = 3'b010; ALU_result = 32'h500; rd_in = 5'd21;
    step();
    req_valid = 0; MemRead = 0;
    check_eq("mid_req", dmem_bus.dmem_req, 1);
    #2 rst = 1;
    #1;
    check_eq("async_req_drop", dmem_bus.dmem_req, 0);
    check_reset_values();
    step();
    rst = 0;
    step();
    check_eq("rel_lvalid", load_valid, 0);
    check_eq("rel_fault", fault, 0);
    do_op(1, 0, 3'b010, 32'h600, 0, 5'd22, 0, 32'h1357_9BDF);

    // randomized operations
    for (int i = 0; i < 200; i++) begin
      bit rd, wr;
      logic [2:0] f3;
      int r = $urandom_range(0, 19);
      rd = (r < 9) || (r == 18);
      wr = (r >= 9 && r < 18) || (r == 18);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) | (rd ? 3'($urandom_range(0, 1)) << 2 : 3'd0));
      do_op(rd, wr, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, TMO), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
